apb_event_reporter: RTL and testbench
=====================================

# apb_event_reporter

Parametrised event-counter-to-APB reporter. It counts pulses on NUM_EVENTS independent event inputs and reports each non-zero count as an APB write. Writes go to a per-channel address and are served in round-robin order with full APB SETUP/ACCESS phasing. It replaces the fixed three-channel event writer. The block sits between event sources and the APB interconnect as the sole requester on its port.

## Interface
- NUM_EVENTS, 4: number of event channels, 2..16
- CNT_W, 16: per-channel counter width, 1..31
- ADDR_BASE, 32'hABBA_0000: APB address of channel 0
- ADDR_STRIDE, 32'h0001_0000: address increment per channel
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- event_i  in  NUM_EVENTS  one pulse per cycle per channel, sampled at posedge clk
- apb_psel_o  out  1  APB select
- apb_penable_o  out  1  APB enable
- apb_pwrite_o  out  1  constant 1 (write-only)
- apb_paddr_o  out  32  ADDR_BASE + idx*ADDR_STRIDE
- apb_pwdata_o  out  32  {ovf, zero pad, count[CNT_W-1:0]}
- apb_pready_i  in  1  APB ready
- apb_pslverr_i  in  1  APB slave error, valid with pready
- err_o  out  1  sticky: a transfer completed with pslverr; cleared only by reset

## Operation
- Per channel: counter cnt[i] (CNT_W bits) and sticky overflow flag ovf[i].
  - An event increments cnt[i].
  - At all-ones, cnt[i] saturates and ovf[i] sets.
- pending[i] = (cnt[i] != 0) | ovf[i].
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: if any pending bit is set, the round-robin arbiter grants channel g. The block goes to SETUP.
  - SETUP: psel=1, penable=0. Always goes to ACCESS on the next edge.
  - ACCESS: psel=1, penable=1. Holds until pready=1.
    - On pready with another channel pending: goes directly to SETUP with the new grant.
    - Otherwise: returns to IDLE.
- Capture (on the edge that enters SETUP):
  - Load the address/data registers from channel g.
  - cnt[g] <= event_i[g] ? 1 : 0.
  - ovf[g] <= 0.
  - Events are never lost except by saturation.
- paddr and pwdata are registered. They stay stable from SETUP through the end of ACCESS.
- Round-robin:
  - Pointer last = most recently granted index. Search starts at last+1 and wraps modulo NUM_EVENTS.
  - Reset value of last is NUM_EVENTS-1, so channel 0 has first priority.
- A channel is not re-granted while its own transfer is in flight. Its new events accumulate in cnt.
- pslverr sampled with pready sets err_o. The reported data is not retried.
- Arithmetic:
  - Address = ADDR_BASE + idx*ADDR_STRIDE, modulo 2^32.
  - pwdata[31] = ovf, pwdata[CNT_W-1:0] = count, all other bits 0.

## Timing
- Reset state: all outputs 0 except pwrite=1. FSM in IDLE; all cnt, ovf and err at 0.
- Reset asserted mid-transfer drops psel/penable immediately (asynchronous) and discards pending counts.
- Event-to-SETUP latency:
  - Event sampled at edge 0; cnt=1 after edge 0.
  - Arbiter sees pending in IDLE; SETUP is entered at edge 1.
  - ACCESS is entered at edge 2.
- Minimum transfer is 2 cycles (SETUP + one ACCESS cycle with pready=1).
- Back-to-back transfers need no IDLE cycle between them.
- An event in the capture cycle of its own channel is counted in the next report (cnt=1).
- An event during ACCESS of its own channel adds to cnt. It does not affect pwdata.
- Simultaneous events on all channels are all counted. They are reported in round-robin order.

## Structure
- Package apb_event_pkg holds:
  - the state_t enum (IDLE, SETUP, ACCESS);
  - APB_AW = APB_DW = 32;
  - OVF_BIT = 31.
- Sub-module rr_arbiter #(N):
  - Inputs: req[N], advance. Outputs: grant_valid, grant_idx[$clog2(N)].
  - Internal last pointer, updated on advance.
- Top level holds the counter array, FSM, capture registers and err flag.

## Test plan
- Reset, then a single event_i[1] pulse, with pready tied 1:
  - SETUP 2 edges later with paddr=32'hABBB_0000, pwdata=1.
  - ACCESS for one cycle, then IDLE.
- All four events pulsed together once, pready=1:
  - Four back-to-back writes in channel order 0,1,2,3.
  - Each has pwdata=1; psel stays high for 8 cycles.
- CNT_W=4, channel 0 held high for 20 cycles with pready=0 on an earlier channel-2 transfer:
  - Channel 0 report is pwdata=32'h8000_000F.
  - ovf is cleared afterwards.
- pready held 0 for 5 ACCESS cycles:
  - paddr, pwdata, psel and penable stay stable.
  - 3 events on the same channel meanwhile produce a subsequent report of 3.
- pslverr=1 with pready on one transfer:
  - err_o rises the next cycle and stays 1.
  - The next transfer proceeds normally.
- Reset pulsed during ACCESS:
  - psel and penable drop in the same cycle.
  - After release, no transfer occurs until a new event arrives.

Source files
------------

// File: rtl/apb_event_pkg.sv
// apb_event_pkg: shared FSM state type and APB bus constants for the event reporter
package apb_event_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam int APB_AW  = 32;
    localparam int APB_DW  = 32;
    localparam int OVF_BIT = 31;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin request arbiter; the search starts just after the last grant
//   clk, reset    : clock, asynchronous active-high reset
//   req_i         : per-channel request vector
//   advance_i     : accept the current grant and move the pointer to it
//   grant_valid_o : some request is set
//   grant_idx_o   : granted channel index
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_i,
    input  logic                 advance_i,
    output logic                 grant_valid_o,
    output logic [$clog2(N)-1:0] grant_idx_o
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] last_q, j;

    // Walk from farthest to nearest so the nearest request after last_q wins.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        j             = '0;
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(last_q) + k) % N);
            if (req_i[j]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = j;
            end
        end
    end

    // Reset to the last channel so channel 0 is searched first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= IW'(N - 1);
        else if (advance_i) last_q <= grant_idx_o;
    end

endmodule

// File: rtl/apb_event_reporter.sv
// apb_event_reporter: counts event pulses per channel and reports non-zero counts as APB writes
//   clk, reset         : clock, asynchronous active-high reset
//   event_i            : one pulse per cycle per channel
//   apb_psel_o/penable : APB phase control (SETUP, then ACCESS until pready)
//   apb_pwrite_o       : always 1, the block only writes
//   apb_paddr_o        : ADDR_BASE + channel*ADDR_STRIDE
//   apb_pwdata_o       : {ovf, zero pad, count}
//   apb_pready_i       : completes ACCESS
//   apb_pslverr_i      : slave error, sampled with pready
//   err_o              : sticky slave-error flag
module apb_event_reporter
    import apb_event_pkg::*;
#(
    parameter int                NUM_EVENTS  = 4,
    parameter int                CNT_W       = 16,
    parameter logic [APB_AW-1:0] ADDR_BASE   = 32'hABBA_0000,
    parameter logic [APB_AW-1:0] ADDR_STRIDE = 32'h0001_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic                  apb_psel_o,
    output logic                  apb_penable_o,
    output logic                  apb_pwrite_o,
    output logic [APB_AW-1:0]     apb_paddr_o,
    output logic [APB_DW-1:0]     apb_pwdata_o,
    input  logic                  apb_pready_i,
    input  logic                  apb_pslverr_i,
    output logic                  err_o
);
    localparam int IW = $clog2(NUM_EVENTS);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] ovf_q, pending, req;
    logic [IW-1:0]         cur_q, grant_idx;
    logic                  grant_valid, capture, err_q;
    logic [APB_AW-1:0]     paddr_q, paddr_d;
    logic [APB_DW-1:0]     pwdata_q, pwdata_d;

    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_EVENTS; i++) pending[i] = (cnt_q[i] != '0) | ovf_q[i];
    end

    // The channel whose transfer is finishing may not be granted again straight away.
    assign req = (state_q == ACCESS) ? pending & ~(NUM_EVENTS'(1) << cur_q) : pending;

    rr_arbiter #(.N(NUM_EVENTS)) u_arb (
        .clk           (clk),
        .reset         (reset),
        .req_i         (req),
        .advance_i     (capture),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    always_comb begin
        capture  = grant_valid && (state_q == IDLE || (state_q == ACCESS && apb_pready_i));
        state_d  = state_q;
        case (state_q)
            IDLE:    state_d = grant_valid ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = apb_pready_i ? (grant_valid ? SETUP : IDLE) : ACCESS;
            default: state_d = IDLE;
        endcase
        paddr_d           = ADDR_BASE + APB_AW'(grant_idx) * ADDR_STRIDE;
        pwdata_d          = APB_DW'(cnt_q[grant_idx]);
        pwdata_d[OVF_BIT] = ovf_q[grant_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            err_q    <= 1'b0;
            ovf_q    <= '0;
            for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                cur_q    <= grant_idx;
                paddr_q  <= paddr_d;
                pwdata_q <= pwdata_d;
            end
            if (state_q == ACCESS && apb_pready_i && apb_pslverr_i) err_q <= 1'b1;
            // A captured channel restarts from its same-cycle event so nothing is dropped.
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (capture && grant_idx == IW'(i)) begin
                    cnt_q[i] <= event_i[i] ? CNT_W'(1) : '0;
                    ovf_q[i] <= 1'b0;
                end else if (event_i[i]) begin
                    if (&cnt_q[i]) ovf_q[i] <= 1'b1;
                    else cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign apb_psel_o    = state_q != IDLE;
    assign apb_penable_o = state_q == ACCESS;
    assign apb_pwrite_o  = 1'b1;
    assign apb_paddr_o   = paddr_q;
    assign apb_pwdata_o  = pwdata_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_apb_event_reporter.sv
// tb_apb_event_reporter: vector table plus corner sequences, writes checked against a scoreboard
module tb_apb_event_reporter;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [3:0] ev;
        int         n_writes;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  event_i = '0;
    logic        pready = 1'b1;
    logic        pslverr = 1'b0;
    logic        psel, penable, pwrite, err;
    logic [31:0] paddr, pwdata;

    int   n_tests = 0;
    int   n_fail = 0;
    int   rr_last = 3;
    int   rr_start;
    int   psel_cycles = 0;
    int   psel_runs = 0;
    logic psel_prev = 1'b0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[5];

    apb_event_reporter #(.NUM_EVENTS(4), .CNT_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .event_i       (event_i),
        .apb_psel_o    (psel),
        .apb_penable_o (penable),
        .apb_pwrite_o  (pwrite),
        .apb_paddr_o   (paddr),
        .apb_pwdata_o  (pwdata),
        .apb_pready_i  (pready),
        .apb_pslverr_i (pslverr),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int ch);
        return 32'hABBA_0000 + 32'(ch) * 32'h0001_0000;
    endfunction

    task automatic push_exp(input int ch, input logic [31:0] d);
        exp_t e;
        e.addr = addr_of(ch);
        e.data = d;
        sb.push_back(e);
        rr_last = ch;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] mask);
        tick();
        event_i = mask;
        tick();
        event_i = '0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !psel) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL drain_timeout: %0d writes still outstanding, required 0", sb.size());
    endtask

    task automatic wait_access();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (psel && penable) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL access_timeout: ACCESS phase not reached, required within 50 cycles");
    endtask

    // Completed writes are popped from the scoreboard in issue order.
    always @(negedge clk) begin
        if (!reset) begin
            psel_cycles += int'(psel);
            if (psel && !psel_prev) psel_runs++;
            if (psel && penable && pready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h data %h, required no write", paddr, pwdata);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wr_addr", paddr, mon_e.addr);
                    chk("wr_data", pwdata, mon_e.data);
                    chk("wr_pwrite", 32'(pwrite), 32'd1);
                end
            end
            psel_prev = psel;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'b1111, 4};
        vecs[1] = '{4'b0010, 1};
        vecs[2] = '{4'b0101, 2};
        vecs[3] = '{4'b1001, 2};
        vecs[4] = '{4'b0001, 1};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd1);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        for (int v = 0; v < 5; v++) begin
            tick();
            rr_start = rr_last;
            for (int k = 1; k <= 4; k++)
                if (vecs[v].ev[(rr_start + k) % 4]) push_exp((rr_start + k) % 4, 32'd1);
            psel_cycles = 0;
            psel_runs = 0;
            pulse(vecs[v].ev);
            wait_drain();
            chk("vec_psel_cycles", 32'(psel_cycles), 32'(2 * vecs[v].n_writes));
            chk("vec_psel_runs", 32'(psel_runs), 32'd1);
        end

        tick();
        push_exp(1, 32'd1);
        event_i = 4'b0010;
        @(posedge clk);
        #1 event_i = '0;
        @(posedge clk);
        @(negedge clk);
        chk("lat_setup_psel", 32'(psel), 32'd1);
        chk("lat_setup_penable", 32'(penable), 32'd0);
        chk("lat_setup_paddr", paddr, 32'hABBB_0000);
        chk("lat_setup_pwdata", pwdata, 32'd1);
        @(negedge clk);
        chk("lat_access_psel", 32'(psel), 32'd1);
        chk("lat_access_penable", 32'(penable), 32'd1);
        @(negedge clk);
        chk("lat_idle_psel", 32'(psel), 32'd0);
        wait_drain();

        tick();
        pready = 1'b0;
        push_exp(2, 32'd1);
        pulse(4'b0100);
        wait_access();
        push_exp(0, 32'h8000_000F);
        tick();
        event_i = 4'b0001;
        repeat (20) tick();
        event_i = '0;
        tick();
        pready = 1'b1;
        wait_drain();
        tick();
        push_exp(0, 32'd1);
        pulse(4'b0001);
        wait_drain();

        tick();
        pready = 1'b0;
        push_exp(3, 32'd1);
        pulse(4'b1000);
        wait_access();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 event_i = (i < 3) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            chk("stall_psel", 32'(psel), 32'd1);
            chk("stall_penable", 32'(penable), 32'd1);
            chk("stall_paddr", paddr, 32'hABBD_0000);
            chk("stall_pwdata", pwdata, 32'd1);
        end
        push_exp(3, 32'd3);
        tick();
        pready = 1'b1;
        wait_drain();

        tick();
        pslverr = 1'b1;
        push_exp(1, 32'd1);
        pulse(4'b0010);
        wait_access();
        chk("err_before", 32'(err), 32'd0);
        @(posedge clk);
        #1 pslverr = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        push_exp(2, 32'd1);
        pulse(4'b0100);
        wait_drain();
        chk("err_sticky", 32'(err), 32'd1);

        tick();
        pready = 1'b0;
        push_exp(0, 32'd1);
        pulse(4'b0001);
        wait_access();
        tick();
        event_i = 4'b0010;
        tick();
        event_i = '0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_psel", 32'(psel), 32'd0);
        chk("rst_mid_penable", 32'(penable), 32'd0);
        sb.delete();
        rr_last = 3;
        tick();
        tick();
        reset = 1'b0;
        pready = 1'b1;
        chk("rst_mid_err", 32'(err), 32'd0);
        psel_cycles = 0;
        repeat (10) tick();
        chk("rst_no_xfer", 32'(psel_cycles), 32'd0);
        push_exp(2, 32'd1);
        pulse(4'b0100);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
